// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Shares one dual-port Block_RAM (port A = byte-enabled write, port B =
//   read with a 1-cycle registered output) between two masters:
//   M0 (CPU data side) and M1 (DMA/loader).
//
//   The write port and the read port each have their own round-robin arbiter,
//   so a read by one master and a write by the other can both be accepted in
//   the same cycle. A master may hold a port for a short locked burst of up to
//   MAX_BURST consecutive grants while the other master waits.
//
//   Handshake: a master raises mX_req with we/addr/wdata/be/lock stable and
//   keeps them stable until mX_gnt. mX_gnt is combinational (zero-wait), and
//   the transfer completes on the clock edge where req & gnt are both high.
//   A granted read returns on mX_rvalid/mX_rdata exactly one cycle later.
//
// Ports
//   HCLK, HRESETn                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata/be/lock   request from master X (X = 0,1)
//   mX_gnt                         request accepted this cycle
//   mX_rvalid, mX_rdata            read return, one cycle after the read grant
//   ram_addra/dina/wea             Block_RAM write port
//   ram_addrb, ram_doutb           Block_RAM read port
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_BURST  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_be,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_be,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  localparam int             CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAXC = CW'(MAX_BURST);

  // Per-port arbiter state: last granted master and locked-burst length.
  // A non-zero count means the previous cycle accepted a locked transfer
  // on that port, so the lock is only honoured across back-to-back grants.
  logic                  last_w_q, last_w_d;
  logic                  last_r_q, last_r_d;
  logic [CW-1:0]         cnt_w_q,  cnt_w_d;
  logic [CW-1:0]         cnt_r_q,  cnt_r_d;
  // Read-return pipeline.
  logic                  rd_pend_q,  rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;
  logic [ADDR_WIDTH-1:0] addrb_q,    addrb_d;

  logic wr0, wr1, rd0, rd1;
  logic w_any, w_win, r_any, r_win;
  logic w_lock, r_lock;

  // Winner index when at least one of r0/r1 is set.
  function automatic logic arb_pick(input logic r0, input logic r1,
                                    input logic last, input logic [CW-1:0] cnt);
    logic win;
    if (r0 && r1) begin
      // Locked owner keeps the port until the burst cap, then round-robin.
      win = (cnt != '0 && cnt < MAXC) ? last : ~last;
    end else begin
      win = r1;
    end
    return win;
  endfunction

  function automatic logic [CW-1:0] cnt_next(input logic any, input logic win,
                                             input logic last, input logic lock,
                                             input logic [CW-1:0] cnt);
    logic [CW-1:0] nxt;
    if (!any || !lock)   nxt = '0;
    else if (win == last) nxt = (cnt == MAXC) ? cnt : cnt + 1'b1;
    else                  nxt = CW'(1);
    return nxt;
  endfunction

  always_comb begin
    wr0   = m0_req &  m0_we;
    wr1   = m1_req &  m1_we;
    rd0   = m0_req & ~m0_we;
    rd1   = m1_req & ~m1_we;

    w_any = wr0 | wr1;
    r_any = rd0 | rd1;
    w_win = arb_pick(wr0, wr1, last_w_q, cnt_w_q);
    r_win = arb_pick(rd0, rd1, last_r_q, cnt_r_q);
    w_lock = w_win ? m1_lock : m0_lock;
    r_lock = r_win ? m1_lock : m0_lock;

    last_w_d   = w_any ? w_win : last_w_q;
    last_r_d   = r_any ? r_win : last_r_q;
    cnt_w_d    = cnt_next(w_any, w_win, last_w_q, w_lock, cnt_w_q);
    cnt_r_d    = cnt_next(r_any, r_win, last_r_q, r_lock, cnt_r_q);
    rd_pend_d  = r_any;
    rd_owner_d = r_any ? r_win : rd_owner_q;

    // Read address holds its last value while the read port is idle.
    ram_addrb = r_any ? (r_win ? m1_addr : m0_addr) : addrb_q;
    addrb_d   = ram_addrb;

    ram_addra = w_win ? m1_addr  : m0_addr;
    ram_dina  = w_win ? m1_wdata : m0_wdata;
    // Grants and write enables are forced low while reset is asserted.
    ram_wea   = (w_any && HRESETn) ? (w_win ? m1_be : m0_be) : 4'b0000;

    m0_gnt = HRESETn & ((w_any & ~w_win) | (r_any & ~r_win));
    m1_gnt = HRESETn & ((w_any &  w_win) | (r_any &  r_win));

    m0_rvalid = rd_pend_q & ~rd_owner_q;
    m1_rvalid = rd_pend_q &  rd_owner_q;
    m0_rdata  = m0_rvalid ? ram_doutb : 32'h0;
    m1_rdata  = m1_rvalid ? ram_doutb : 32'h0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_w_q   <= 1'b1;
      last_r_q   <= 1'b1;
      cnt_w_q    <= '0;
      cnt_r_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      addrb_q    <= '0;
    end else begin
      last_w_q   <= last_w_d;
      last_r_q   <= last_r_d;
      cnt_w_q    <= cnt_w_d;
      cnt_r_q    <= cnt_r_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      addrb_q    <= addrb_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//   Directed vector table, hand-written burst/reset sequences and a random
//   phase checked against a transaction-level model of the two arbiters and
//   the memory contents. Includes a behavioural Block_RAM.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int AW        = 14;
  localparam int MAX_BURST = 8;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          lock;
  } op_t;

  typedef struct {
    op_t         a;
    op_t         b;
    logic        g0;
    logic        g1;
    logic [3:0]  wea;
    logic        v0;
    logic        v1;
    logic [31:0] rd;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic HCLK;
  logic HRESETn;
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic [3:0]    m0_be;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [3:0]    m1_be;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MAX_BURST)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // Behavioural Block_RAM: byte-enabled write, registered read-before-write.
  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) bram[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
    ram_doutb <= bram[ram_addrb];
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];           // {master, data} of the read returning next cycle
  logic [31:0] exp_mem [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  function automatic op_t op_idle();
    op_t o;
    o.req = 1'b0; o.we = 1'b0; o.addr = '0; o.wdata = '0; o.be = '0; o.lock = 1'b0;
    return o;
  endfunction

  function automatic op_t op_w(input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic lk);
    op_t o;
    o.req = 1'b1; o.we = 1'b1; o.addr = a; o.wdata = d; o.be = be; o.lock = lk;
    return o;
  endfunction

  function automatic op_t op_r(input logic [AW-1:0] a, input logic lk);
    op_t o;
    o = op_idle();
    o.req = 1'b1; o.addr = a; o.lock = lk;
    return o;
  endfunction

  function automatic vec_t mkv(input op_t a, input op_t b, input logic g0, input logic g1,
                               input logic [3:0] wea, input logic v0, input logic v1,
                               input logic [31:0] rd);
    vec_t v;
    v.a = a; v.b = b; v.g0 = g0; v.g1 = g1; v.wea = wea; v.v0 = v0; v.v1 = v1; v.rd = rd;
    return v;
  endfunction

  task automatic apply(input op_t a, input op_t b);
    m0_req = a.req; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wdata;
    m0_be = a.be; m0_lock = a.lock;
    m1_req = b.req; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wdata;
    m1_be = b.be; m1_lock = b.lock;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 32'h0;
  endfunction

  // ---------------- reference model state (random phase) ----------------
  int   last_m [2];   // index 0 = write port, 1 = read port
  int   streak [2];
  bit   plock  [2];
  op_t  cur    [2];
  bit   busy   [2];
  int   g      [2];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    op_t  idle;
    int   m1_run;
    bit   m0_done;
    int   cyc;

    for (int i = 0; i < (1 << AW); i++) bram[i] = 32'h0;
    idle = op_idle();

    // ---- reset: outputs quiet even with a request present ----
    HRESETn = 1'b0;
    apply(op_w(14'h001, 32'h1, 4'hF, 1'b0), idle);
    repeat (2) @(posedge HCLK);
    #5;
    chk("rst_gnt0",   32'(m0_gnt),    32'd0);
    chk("rst_gnt1",   32'(m1_gnt),    32'd0);
    chk("rst_wea",    32'(ram_wea),   32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    apply(idle, idle);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    next_cycle();

    // ---- directed table ----
    // write/read-back
    vt.push_back(mkv(op_w(14'h010, 32'hDEADBEEF, 4'hF, 0), idle, 1, 0, 4'hF, 0, 0, 32'h0));
    vt.push_back(mkv(op_r(14'h010, 0), idle,                    1, 0, 4'h0, 0, 0, 32'h0));
    vt.push_back(mkv(idle, idle,                                0, 0, 4'h0, 1, 0, 32'hDEADBEEF));
    // same-cycle read and write to one address: old data returned
    vt.push_back(mkv(op_r(14'h020, 0), op_w(14'h020, 32'h12345678, 4'hF, 0),
                     1, 1, 4'hF, 0, 0, 32'h0));
    vt.push_back(mkv(op_r(14'h020, 0), idle,                    1, 0, 4'h0, 1, 0, 32'h0));
    vt.push_back(mkv(idle, idle,                                0, 0, 4'h0, 1, 0, 32'h12345678));
    // both read every cycle: alternation (M0 read last, so M1 first)
    for (int k = 0; k < 6; k++) begin
      logic gm1;
      gm1 = (k % 2 == 0);
      vt.push_back(mkv(op_r(14'h010, 0), op_r(14'h020, 0), !gm1, gm1, 4'h0,
                       (k > 0) && gm1, (k > 0) && !gm1,
                       (k == 0) ? 32'h0 : (gm1 ? 32'hDEADBEEF : 32'h12345678)));
    end
    vt.push_back(mkv(idle, idle,                                0, 0, 4'h0, 1, 0, 32'hDEADBEEF));
    // byte lanes and an empty write
    vt.push_back(mkv(op_w(14'h030, 32'hAABBCCDD, 4'hF, 0), idle, 1, 0, 4'hF, 0, 0, 32'h0));
    vt.push_back(mkv(op_w(14'h030, 32'h00001100, 4'h2, 0), idle, 1, 0, 4'h2, 0, 0, 32'h0));
    vt.push_back(mkv(idle, op_w(14'h030, 32'hFFFFFFFF, 4'h0, 0), 0, 1, 4'h0, 0, 0, 32'h0));
    vt.push_back(mkv(idle, op_r(14'h030, 0),                    0, 1, 4'h0, 0, 0, 32'h0));
    vt.push_back(mkv(idle, idle,                                0, 0, 4'h0, 0, 1, 32'hAABB11DD));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].a, vt[i].b);
      #4;
      chk($sformatf("row%0d_gnt0", i),   32'(m0_gnt),    32'(vt[i].g0));
      chk($sformatf("row%0d_gnt1", i),   32'(m1_gnt),    32'(vt[i].g1));
      chk($sformatf("row%0d_wea", i),    32'(ram_wea),   32'(vt[i].wea));
      chk($sformatf("row%0d_rvalid0", i), 32'(m0_rvalid), 32'(vt[i].v0));
      chk($sformatf("row%0d_rvalid1", i), 32'(m1_rvalid), 32'(vt[i].v1));
      chk($sformatf("row%0d_rdata0", i), m0_rdata, vt[i].v0 ? vt[i].rd : 32'h0);
      chk($sformatf("row%0d_rdata1", i), m1_rdata, vt[i].v1 ? vt[i].rd : 32'h0);
      next_cycle();
    end

    // ---- locked burst: M1 starts alone, M0 joins and must get in after MAX_BURST ----
    m1_run  = 0;
    m0_done = 1'b0;
    cyc     = 0;
    apply(idle, op_w(14'h040, 32'h40, 4'hF, 1'b1));
    #4;
    if (m1_gnt) m1_run++;
    next_cycle();
    while (!m0_done && cyc < 30) begin
      cyc++;
      apply(op_w(14'h060, 32'h60, 4'hF, 1'b0), op_w(AW'(14'h040 + cyc), 32'(cyc), 4'hF, 1'b1));
      #4;
      chk("burst_one_gnt", 32'(m0_gnt) + 32'(m1_gnt), 32'd1);
      if (m0_gnt) m0_done = 1'b1;
      else if (m1_gnt) m1_run++;
      next_cycle();
    end
    chk("burst_m0_served", 32'(m0_done), 32'd1);
    chk("burst_len", 32'(m1_run), 32'(MAX_BURST));
    apply(idle, idle);
    next_cycle();

    // ---- reset during an in-flight read ----
    apply(idle, op_r(14'h020, 1'b1));
    #4;
    chk("rst6_gnt_a", 32'(m1_gnt), 32'd1);
    next_cycle();
    #4;
    chk("rst6_gnt_b", 32'(m1_gnt), 32'd1);
    apply(idle, idle);
    HRESETn = 1'b0;
    next_cycle();
    apply(op_r(14'h010, 1'b0), op_r(14'h020, 1'b1));
    #4;
    chk("rst6_no_rvalid1", 32'(m1_rvalid), 32'd0);
    chk("rst6_no_rdata1",  m1_rdata,       32'h0);
    chk("rst6_gnt_in_rst", 32'({m0_gnt, m1_gnt}), 32'd0);
    apply(idle, idle);
    next_cycle();
    HRESETn = 1'b1;
    apply(op_r(14'h010, 1'b0), op_r(14'h020, 1'b1));
    #4;
    chk("rst6_first_m0", 32'(m0_gnt), 32'd1);
    chk("rst6_first_m1", 32'(m1_gnt), 32'd0);
    next_cycle();
    apply(idle, op_r(14'h020, 1'b1));
    #4;
    chk("rst6_m1_gnt",   32'(m1_gnt),    32'd1);
    chk("rst6_m0_rv",    32'(m0_rvalid), 32'd1);
    chk("rst6_m0_rd",    m0_rdata,       32'hDEADBEEF);
    next_cycle();
    apply(idle, idle);
    #4;
    chk("rst6_m1_rv",    32'(m1_rvalid), 32'd1);
    chk("rst6_m1_rd",    m1_rdata,       32'h12345678);
    next_cycle();

    // ---- randomized phase against the reference model ----
    HRESETn = 1'b0;
    next_cycle();
    HRESETn = 1'b1;
    for (int p = 0; p < 2; p++) begin
      last_m[p] = 1; streak[p] = 0; plock[p] = 1'b0;
      busy[p] = 1'b0; cur[p] = op_idle();
    end

    for (int t = 0; t < 500; t++) begin
      logic [32:0] e;
      op_t a0, a1;
      for (int m = 0; m < 2; m++) begin
        if (!busy[m] && $urandom_range(0, 3) != 0) begin
          cur[m].req   = 1'b1;
          cur[m].we    = 1'($urandom_range(0, 1));
          cur[m].addr  = AW'(14'h200 + $urandom_range(0, 15));
          cur[m].wdata = $urandom;
          cur[m].be    = 4'($urandom_range(0, 15));
          cur[m].lock  = 1'($urandom_range(0, 1));
          busy[m] = 1'b1;
        end
      end
      a0 = busy[0] ? cur[0] : op_idle();
      a1 = busy[1] ? cur[1] : op_idle();
      apply(a0, a1);
      #4;

      // arbitration by rule: port 0 = writes, port 1 = reads
      for (int p = 0; p < 2; p++) begin
        bit q0, q1;
        q0 = busy[0] && (cur[0].we == (p == 0));
        q1 = busy[1] && (cur[1].we == (p == 0));
        if (q0 && q1)  g[p] = (plock[p] && streak[p] < MAX_BURST) ? last_m[p] : 1 - last_m[p];
        else if (q0)   g[p] = 0;
        else if (q1)   g[p] = 1;
        else           g[p] = -1;
      end

      chk("rnd_gnt0", 32'(m0_gnt), 32'(g[0] == 0 || g[1] == 0));
      chk("rnd_gnt1", 32'(m1_gnt), 32'(g[0] == 1 || g[1] == 1));
      if (g[0] >= 0) begin
        chk("rnd_wea",   32'(ram_wea),   32'(cur[g[0]].be));
        chk("rnd_addra", 32'(ram_addra), 32'(cur[g[0]].addr));
        chk("rnd_dina",  ram_dina,       cur[g[0]].wdata);
      end else begin
        chk("rnd_wea_idle", 32'(ram_wea), 32'd0);
      end
      if (g[1] >= 0) chk("rnd_addrb", 32'(ram_addrb), 32'(cur[g[1]].addr));

      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rnd_rvalid0", 32'(m0_rvalid), 32'(e[32] == 1'b0));
        chk("rnd_rvalid1", 32'(m1_rvalid), 32'(e[32] == 1'b1));
        chk("rnd_rdata",   e[32] ? m1_rdata : m0_rdata, e[31:0]);
      end else begin
        chk("rnd_rvalid_idle", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      end

      // read sees memory before this cycle's write
      if (g[1] >= 0) exp_q.push_back({1'(g[1]), mem_rd(cur[g[1]].addr)});
      if (g[0] >= 0) begin
        logic [31:0] w;
        w = mem_rd(cur[g[0]].addr);
        for (int i = 0; i < 4; i++)
          if (cur[g[0]].be[i]) w[8*i +: 8] = cur[g[0]].wdata[8*i +: 8];
        exp_mem[int'(cur[g[0]].addr)] = w;
      end

      for (int p = 0; p < 2; p++) begin
        if (g[p] >= 0) begin
          if (cur[g[p]].lock) begin
            if (g[p] == last_m[p] && plock[p])
              streak[p] = (streak[p] < MAX_BURST) ? streak[p] + 1 : MAX_BURST;
            else
              streak[p] = 1;
            plock[p] = 1'b1;
          end else begin
            streak[p] = 0;
            plock[p]  = 1'b0;
          end
          last_m[p] = g[p];
          busy[g[p]] = 1'b0;
        end else begin
          streak[p] = 0;
          plock[p]  = 1'b0;
        end
      end
      next_cycle();
    end

    // drain the last read return
    apply(op_idle(), op_idle());
    #4;
    if (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      chk("drain_rvalid", 32'(e[32] ? m1_rvalid : m0_rvalid), 32'd1);
      chk("drain_rdata",  e[32] ? m1_rdata : m0_rdata, e[31:0]);
    end else begin
      chk("drain_rvalid_idle", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    end
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
